// File: rtl/rv_check_pkg.sv
// Shared types for the RV32I writeback checker: FSM states, the expected-table
// entry layout and the single-entry compare rule.
package rv_check_pkg;

  localparam int CHK_XLEN    = 32;
  localparam int CHK_RADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PASS,
    FAIL
  } check_state_t;

  typedef struct packed {
    logic                   write;
    logic [CHK_RADDR_W-1:0] waddr;
    logic [CHK_XLEN-1:0]    wdata;
    logic                   chk_data;
  } exp_entry_t;

  // Destination register is compared even for non-writing entries so that
  // stores and branches still pin down the decoded rd field.
  function automatic logic entry_match(
    input exp_entry_t             e,
    input logic                   write,
    input logic [CHK_RADDR_W-1:0] waddr,
    input logic [CHK_XLEN-1:0]    wdata
  );
    return (write == e.write) && (waddr == e.waddr) &&
           (!e.chk_data || (wdata == e.wdata));
  endfunction

endpackage

// File: rtl/wb_checker_if.sv
// Bundle of table-load, control, retirement-monitor and status signals
// between the checker and whoever drives it.
interface wb_checker_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int IDX_W   = 4
);

  logic               exp_we;
  logic [IDX_W-1:0]   exp_addr;
  logic               exp_write;
  logic [RADDR_W-1:0] exp_waddr;
  logic [XLEN-1:0]    exp_wdata;
  logic               exp_chk_data;

  logic               start;
  logic [IDX_W:0]     num_entries;

  logic               mon_valid;
  logic               mon_write;
  logic [RADDR_W-1:0] mon_waddr;
  logic [XLEN-1:0]    mon_wdata;
  logic [XLEN-1:0]    mon_pc;

  logic               busy;
  logic               done;
  logic               pass;
  logic               fail;
  logic               timeout;
  logic [IDX_W-1:0]   fail_idx;
  logic [XLEN-1:0]    fail_pc;
  logic [XLEN-1:0]    fail_got;
  logic [XLEN-1:0]    fail_exp;
  logic [IDX_W:0]     match_cnt;

  modport master (
    output exp_we, exp_addr, exp_write, exp_waddr, exp_wdata, exp_chk_data,
    output start, num_entries,
    output mon_valid, mon_write, mon_waddr, mon_wdata, mon_pc,
    input  busy, done, pass, fail, timeout,
    input  fail_idx, fail_pc, fail_got, fail_exp, match_cnt
  );

  modport slave (
    input  exp_we, exp_addr, exp_write, exp_waddr, exp_wdata, exp_chk_data,
    input  start, num_entries,
    input  mon_valid, mon_write, mon_waddr, mon_wdata, mon_pc,
    output busy, done, pass, fail, timeout,
    output fail_idx, fail_pc, fail_got, fail_exp, match_cnt
  );

endinterface

// File: rtl/wb_checker_mem.sv
// Expected-retirement table: one synchronous write port, one asynchronous
// read port. Contents deliberately survive reset.
module wb_checker_mem
  import rv_check_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  exp_entry_t       wentry,
  input  logic [IDX_W-1:0] raddr,
  output exp_entry_t       rentry
);

  exp_entry_t entries [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      entries[waddr] <= wentry;
    end
  end

  assign rentry = entries[raddr];

endmodule

// File: rtl/wb_checker.sv
// Writeback scoreboard: checks each retired instruction against the next
// entry of an in-order expected table and latches the first mismatch.
module wb_checker
  import rv_check_pkg::*;
#(
  parameter int XLEN    = CHK_XLEN,
  parameter int RADDR_W = CHK_RADDR_W,
  parameter int DEPTH   = 16,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst,
  wb_checker_if.slave bus
);

  localparam int CNT_W  = IDX_W + 1;
  localparam int WDOG_W = $clog2(TIMEOUT + 1);

  check_state_t      state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  last_idx;
  logic [WDOG_W-1:0] wdog;
  logic [CNT_W-1:0]  match_cnt;

  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              fail_q;
  logic              timeout_q;
  logic [IDX_W-1:0]  fail_idx_q;
  logic [XLEN-1:0]   fail_pc_q;
  logic [XLEN-1:0]   fail_got_q;
  logic [XLEN-1:0]   fail_exp_q;

  exp_entry_t        wr_entry;
  exp_entry_t        cur_entry;
  logic              table_we;
  logic              match;
  logic [CNT_W-1:0]  n_eff;
  logic [RADDR_W-1:0] mon_waddr;

  always_comb begin
    wr_entry          = '0;
    wr_entry.write    = bus.exp_write;
    wr_entry.waddr    = bus.exp_waddr;
    wr_entry.wdata    = bus.exp_wdata;
    wr_entry.chk_data = bus.exp_chk_data;
  end

  // Loads are frozen while a check is running so the table cannot shift under it.
  assign table_we = bus.exp_we && (state != RUN);

  wb_checker_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk    (clk),
    .we     (table_we),
    .waddr  (bus.exp_addr),
    .wentry (wr_entry),
    .raddr  (idx),
    .rentry (cur_entry)
  );

  assign mon_waddr = bus.mon_waddr;
  assign match     = entry_match(cur_entry, bus.mon_write, mon_waddr, bus.mon_wdata);
  assign n_eff     = (bus.num_entries > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.num_entries;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      last_idx   <= '0;
      wdog       <= '0;
      match_cnt  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      fail_idx_q <= '0;
      fail_pc_q  <= '0;
      fail_got_q <= '0;
      fail_exp_q <= '0;
    end else begin
      case (state)
        IDLE, PASS, FAIL: begin
          if (bus.start) begin
            idx        <= '0;
            wdog       <= '0;
            match_cnt  <= '0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            fail_idx_q <= '0;
            fail_pc_q  <= '0;
            fail_got_q <= '0;
            fail_exp_q <= '0;
            if (n_eff == '0) begin
              state  <= PASS;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= 1'b1;
            end else begin
              state    <= RUN;
              last_idx <= IDX_W'(n_eff - 1'b1);
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              pass_q   <= 1'b0;
            end
          end
        end

        RUN: begin
          if (bus.mon_valid) begin
            wdog <= '0;
            if (match) begin
              match_cnt <= match_cnt + 1'b1;
              if (idx == last_idx) begin
                state  <= PASS;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                pass_q <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              state      <= FAIL;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              fail_q     <= 1'b1;
              fail_idx_q <= idx;
              fail_pc_q  <= bus.mon_pc;
              fail_got_q <= bus.mon_wdata;
              fail_exp_q <= XLEN'(cur_entry.wdata);
            end
          // A timeout leaves got/exp at the zeros written when the run started.
          end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
            state      <= FAIL;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            fail_q     <= 1'b1;
            timeout_q  <= 1'b1;
            fail_idx_q <= idx;
            fail_pc_q  <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.timeout   = timeout_q;
  assign bus.fail_idx  = fail_idx_q;
  assign bus.fail_pc   = fail_pc_q;
  assign bus.fail_got  = fail_got_q;
  assign bus.fail_exp  = fail_exp_q;
  assign bus.match_cnt = match_cnt;

endmodule

// File: tb/tb_wb_checker.sv
// Self-checking bench for wb_checker: directed scenarios with literal
// expectations plus randomized runs scored against a behavioural model.
module tb_wb_checker;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int DEPTH   = 16;
  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  wb_checker_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .IDX_W(IDX_W)) bus ();

  wb_checker #(
    .XLEN    (XLEN),
    .RADDR_W (RADDR_W),
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural model: the table as the checker should hold it, and the
  // verdict expressed as "how many entries matched" and "how long it has been quiet".
  logic               t_write [DEPTH];
  logic [RADDR_W-1:0] t_waddr [DEPTH];
  logic [XLEN-1:0]    t_wdata [DEPTH];
  logic               t_chk   [DEPTH];
  bit          m_running, m_passed, m_failed, m_timeout;
  int          m_n, m_matched, m_quiet;
  logic [31:0] m_fidx, m_fpc, m_fgot, m_fexp;

  task automatic model_reset();
    m_running = 0; m_passed = 0; m_failed = 0; m_timeout = 0;
    m_n = 0; m_matched = 0; m_quiet = 0;
    m_fidx = 0; m_fpc = 0; m_fgot = 0; m_fexp = 0;
  endtask

  task automatic model_step();
    if (m_running) begin
      if (bus.mon_valid) begin
        int k;
        k = m_matched;
        m_quiet = 0;
        if (bus.mon_write == t_write[k] && bus.mon_waddr == t_waddr[k] &&
            (!t_chk[k] || bus.mon_wdata == t_wdata[k])) begin
          m_matched++;
          if (m_matched == m_n) begin
            m_running = 0; m_passed = 1;
          end
        end else begin
          m_running = 0; m_failed = 1;
          m_fidx = k; m_fpc = bus.mon_pc; m_fgot = bus.mon_wdata; m_fexp = t_wdata[k];
        end
      end else begin
        m_quiet++;
        if (m_quiet == TIMEOUT) begin
          m_running = 0; m_failed = 1; m_timeout = 1;
          m_fidx = m_matched; m_fpc = 0;
        end
      end
    end else begin
      if (bus.exp_we) begin
        t_write[bus.exp_addr] = bus.exp_write;
        t_waddr[bus.exp_addr] = bus.exp_waddr;
        t_wdata[bus.exp_addr] = bus.exp_wdata;
        t_chk[bus.exp_addr]   = bus.exp_chk_data;
      end
      if (bus.start) begin
        m_n = (int'(bus.num_entries) > DEPTH) ? DEPTH : int'(bus.num_entries);
        m_matched = 0; m_quiet = 0; m_passed = 0; m_failed = 0; m_timeout = 0;
        m_fidx = 0; m_fpc = 0; m_fgot = 0; m_fexp = 0;
        if (m_n == 0) m_passed = 1;
        else m_running = 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  task automatic check_output();
    check("busy", bus.busy, m_running);
    check("done", bus.done, m_passed || m_failed);
    check("pass", bus.pass, m_passed);
    check("fail", bus.fail, m_failed);
    check("timeout", bus.timeout, m_timeout);
    check("fail_idx", bus.fail_idx, m_fidx);
    check("fail_pc", bus.fail_pc, m_fpc);
    check("fail_got", bus.fail_got, m_fgot);
    check("fail_exp", bus.fail_exp, m_fexp);
    check("match_cnt", bus.match_cnt, m_matched);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) check_output();
    end
  end

  task automatic tick();
    @(negedge clk);
    bus.exp_we = 0; bus.start = 0; bus.mon_valid = 0;
  endtask

  task automatic load(input int i, input logic w, input logic [RADDR_W-1:0] a,
                      input logic [XLEN-1:0] d, input logic c);
    tick();
    bus.exp_we = 1; bus.exp_addr = IDX_W'(i);
    bus.exp_write = w; bus.exp_waddr = a; bus.exp_wdata = d; bus.exp_chk_data = c;
  endtask

  task automatic go(input int n);
    tick();
    bus.start = 1; bus.num_entries = (IDX_W+1)'(n);
  endtask

  task automatic retire(input logic w, input logic [RADDR_W-1:0] a,
                        input logic [XLEN-1:0] d, input logic [XLEN-1:0] pc);
    tick();
    bus.mon_valid = 1; bus.mon_write = w; bus.mon_waddr = a; bus.mon_wdata = d; bus.mon_pc = pc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_pass"}, bus.pass, 0);
    check({tag, "_fail"}, bus.fail, 0);
    check({tag, "_timeout"}, bus.timeout, 0);
    check({tag, "_fail_idx"}, bus.fail_idx, 0);
    check({tag, "_fail_pc"}, bus.fail_pc, 0);
    check({tag, "_fail_got"}, bus.fail_got, 0);
    check({tag, "_fail_exp"}, bus.fail_exp, 0);
    check({tag, "_match_cnt"}, bus.match_cnt, 0);
  endtask

  // Randomized runs: mostly matching retirements with occasional corruption,
  // dropped loads, ignored starts and fully quiet runs that must time out.
  task automatic apply_stimulus(input int runs);
    for (int r = 0; r < runs; r++) begin
      bit quiet;
      repeat ($urandom_range(0, 2))
        load($urandom_range(0, DEPTH-1), 1'($urandom), RADDR_W'($urandom_range(0, 3)),
             XLEN'($urandom_range(0, 7)), 1'($urandom));
      go($urandom_range(0, 20));
      quiet = ($urandom_range(0, 7) == 0);
      for (int c = 0; c < 120; c++) begin
        tick();
        if (!m_running) break;
        if (!quiet && $urandom_range(0, 9) < 7) begin
          int k;
          logic w;
          logic [RADDR_W-1:0] a;
          logic [XLEN-1:0] d;
          k = m_matched;
          w = t_write[k]; a = t_waddr[k]; d = t_wdata[k];
          if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 2))
              0: w = ~w;
              1: a = a ^ RADDR_W'(1 << $urandom_range(0, RADDR_W-1));
              default: d = d ^ XLEN'(1 << $urandom_range(0, XLEN-1));
            endcase
          end
          bus.mon_valid = 1; bus.mon_write = w; bus.mon_waddr = a;
          bus.mon_wdata = d; bus.mon_pc = XLEN'($urandom);
        end
        if ($urandom_range(0, 19) == 0) begin
          bus.exp_we = 1; bus.exp_addr = IDX_W'($urandom); bus.exp_write = 1'($urandom);
          bus.exp_waddr = RADDR_W'($urandom); bus.exp_wdata = XLEN'($urandom);
          bus.exp_chk_data = 1'($urandom);
        end
        if ($urandom_range(0, 29) == 0) begin
          bus.start = 1; bus.num_entries = (IDX_W+1)'($urandom_range(0, 20));
        end
      end
    end
  endtask

  initial begin
    logic               w16 [16];
    logic [RADDR_W-1:0] a16 [16];
    logic [XLEN-1:0]    d16 [16];
    int                 cnt;

    bus.exp_we = 0; bus.exp_addr = 0; bus.exp_write = 0; bus.exp_waddr = 0;
    bus.exp_wdata = 0; bus.exp_chk_data = 0; bus.start = 0; bus.num_entries = 0;
    bus.mon_valid = 0; bus.mon_write = 0; bus.mon_waddr = 0; bus.mon_wdata = 0; bus.mon_pc = 0;
    #1 rst = 0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1;
    chk_en = 1;

    for (int i = 0; i < DEPTH; i++) load(i, 1'b1, RADDR_W'(i), XLEN'(i * 3), 1'b1);

    // Three matching retirements pass one cycle after the last sample.
    load(0, 1, 1, 32'h3E8, 1);
    load(1, 1, 2, 32'h3C0, 1);
    load(2, 1, 3, 32'h3E8, 1);
    go(3);
    retire(1, 1, 32'h3E8, 32'h0);
    retire(1, 2, 32'h3C0, 32'h4);
    retire(1, 3, 32'h3E8, 32'h8);
    tick();
    check("t1_pass", bus.pass, 1);
    check("t1_match_cnt", bus.match_cnt, 3);
    check("t1_fail", bus.fail, 0);

    // Data mismatch on the second entry.
    go(3);
    retire(1, 1, 32'h3E8, 32'h0);
    retire(1, 2, 32'h3C1, 32'h4);
    tick();
    check("t2_fail", bus.fail, 1);
    check("t2_fail_idx", bus.fail_idx, 1);
    check("t2_fail_pc", bus.fail_pc, 32'h4);
    check("t2_fail_got", bus.fail_got, 32'h3C1);
    check("t2_fail_exp", bus.fail_exp, 32'h3C0);
    check("t2_match_cnt", bus.match_cnt, 1);
    check("t2_timeout", bus.timeout, 0);

    // Non-writing entries and the data-ignore flag; rd still compared.
    load(0, 0, 8, 32'h8, 1);
    go(1);
    retire(0, 8, 32'h8, 32'h10);
    tick();
    check("t3_store_pass", bus.pass, 1);
    load(0, 0, 8, 32'h8, 0);
    go(1);
    retire(0, 8, 32'hDEAD, 32'h14);
    tick();
    check("t3_nochk_pass", bus.pass, 1);
    check("t3_nochk_match_cnt", bus.match_cnt, 1);
    go(1);
    retire(0, 9, 32'h8, 32'h18);
    tick();
    check("t3_waddr_fail", bus.fail, 1);
    check("t3_waddr_fail_exp", bus.fail_exp, 32'h8);

    // Watchdog: exactly TIMEOUT quiet cycles after the last sample.
    load(0, 1, 1, 32'h3E8, 1);
    go(2);
    retire(1, 1, 32'h3E8, 32'h20);
    tick();
    cnt = 0;
    while (!bus.done && cnt < 200) begin
      tick();
      cnt++;
    end
    check("t4_latency", cnt, 64);
    check("t4_timeout", bus.timeout, 1);
    check("t4_fail_idx", bus.fail_idx, 1);
    check("t4_fail_pc", bus.fail_pc, 0);
    check("t4_match_cnt", bus.match_cnt, 1);

    // Zero entries pass immediately; oversize counts clamp to the table depth.
    go(0);
    tick();
    check("t5_zero_pass", bus.pass, 1);
    check("t5_zero_busy", bus.busy, 0);
    for (int i = 0; i < 16; i++) begin
      w16[i] = 1'($urandom); a16[i] = RADDR_W'($urandom); d16[i] = XLEN'($urandom);
      load(i, w16[i], a16[i], d16[i], 1);
    end
    go(20);
    for (int i = 0; i < 16; i++) retire(w16[i], a16[i], d16[i], XLEN'(i * 4));
    tick();
    check("t5_clamp_pass", bus.pass, 1);
    check("t5_clamp_match_cnt", bus.match_cnt, 16);

    // Load and start in the same cycle: the new entry is the one checked.
    tick();
    bus.exp_we = 1; bus.exp_addr = 0; bus.exp_write = 1; bus.exp_waddr = 5;
    bus.exp_wdata = 32'h55; bus.exp_chk_data = 1;
    bus.start = 1; bus.num_entries = 1;
    retire(1, 5, 32'h55, 32'h30);
    tick();
    check("t5_same_cycle_pass", bus.pass, 1);

    // Loads during a run are dropped; reset mid-run is immediate.
    load(0, 1, 1, 32'h3E8, 1);
    load(1, 1, 2, 32'h3C0, 1);
    load(2, 1, 3, 32'h3E8, 1);
    go(3);
    retire(1, 1, 32'h3E8, 32'h0);
    load(1, 1, 2, 32'h111, 1);
    retire(1, 2, 32'h3C0, 32'h4);
    tick();
    check("t6_mid_busy", bus.busy, 1);
    check("t6_mid_match_cnt", bus.match_cnt, 2);
    #2 rst = 0;
    #1 check_all_zero("t6_async_rst");
    @(negedge clk);
    rst = 1;

    // Re-start from a failure clears every capture, and entry 1 kept its value.
    go(3);
    retire(1, 1, 32'h999, 32'h44);
    tick();
    check("t6_fail", bus.fail, 1);
    check("t6_fail_pc", bus.fail_pc, 32'h44);
    check("t6_fail_got", bus.fail_got, 32'h999);
    go(3);
    tick();
    check("t6_restart_busy", bus.busy, 1);
    check("t6_restart_fail", bus.fail, 0);
    check("t6_restart_fail_pc", bus.fail_pc, 0);
    check("t6_restart_fail_got", bus.fail_got, 0);
    check("t6_restart_fail_exp", bus.fail_exp, 0);
    bus.mon_valid = 1; bus.mon_write = 1; bus.mon_waddr = 1; bus.mon_wdata = 32'h3E8; bus.mon_pc = 0;
    retire(1, 2, 32'h3C0, 32'h4);
    retire(1, 3, 32'h3E8, 32'h8);
    tick();
    check("t6_readback_pass", bus.pass, 1);
    check("t6_readback_match_cnt", bus.match_cnt, 3);

    apply_stimulus(60);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
